// File: rtl/craft_dec_key_schedule.sv
// CRAFT decryption tweakey streamer: emits TK(31)..TK(0) one nibble per valid/ready handshake.
// Define CRAFT_DEC_RC_MERGE_EN to fold the round constant into nibbles 4 and 5 of every round.
module craft_dec_key_schedule #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  output logic [3:0]   out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   round_idx,
  output logic [3:0]   nib_idx,
  output logic         busy,
  output logic         done
);

  // Handshake: a nibble transfers on a rising edge with out_valid & out_ready;
  // out_valid never waits on out_ready, and out/indices hold while ready is low.

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [3:0] A_LAST = 4'h8;
  localparam logic [2:0] B_LAST = 3'h5;
  localparam logic [3:0] Q_TAB [16] = '{4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
                                        4'd11, 4'd3, 4'd7, 4'd4, 4'd6, 4'd0, 4'd1, 4'd13};

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;

  logic [63:0] k0, k1, t, sr;
  logic [3:0]  a, a_prev;
  logic [2:0]  b, b_prev;
  logic [4:0]  round_dec;
  logic [63:0] start_word, next_word;

  // Nibble i of the result takes nibble Q_TAB[i] of the input; nibble 0 is bits 63:60.
  function automatic logic [63:0] q_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[63-4*i -: 4] = x[63-4*int'(Q_TAB[i]) -: 4];
    end
    return y;
  endfunction

  // r_lo is round mod 4: bit 0 picks the key half, bit 1 picks T versus Q(T).
  function automatic logic [63:0] tk_fn(input logic [1:0] r_lo, input logic [63:0] kk0,
                                        input logic [63:0] kk1, input logic [63:0] tt);
    logic [63:0] kh, tw;
    kh = r_lo[0] ? kk1 : kk0;
    tw = r_lo[1] ? q_perm(tt) : tt;
    return kh ^ tw;
  endfunction

`ifdef CRAFT_DEC_RC_MERGE_EN
  function automatic logic [63:0] rc_word(input logic [3:0] ra, input logic [2:0] rb);
    return {16'h0, ra, 1'b0, rb, 40'h0};
  endfunction
`endif

  always_comb begin
    a_prev    = {a[2], a[1], a[0], a[3] ^ a[0]};
    b_prev    = {b[1], b[0], b[2] ^ b[0]};
    round_dec = round_idx - 5'd1;
`ifdef CRAFT_DEC_RC_MERGE_EN
    start_word = tk_fn(LAST_ROUND[1:0], key[127:64], key[63:0], tweak) ^ rc_word(A_LAST, B_LAST);
    next_word  = tk_fn(round_dec[1:0], k0, k1, t) ^ rc_word(a_prev, b_prev);
`else
    start_word = tk_fn(LAST_ROUND[1:0], key[127:64], key[63:0], tweak);
    next_word  = tk_fn(round_dec[1:0], k0, k1, t);
`endif
  end

  assign out = sr[63:60];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k0        <= '0;
      k1        <= '0;
      t         <= '0;
      sr        <= '0;
      a         <= A_LAST;
      b         <= B_LAST;
      round_idx <= '0;
      nib_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k0        <= key[127:64];
            k1        <= key[63:0];
            t         <= tweak;
            sr        <= start_word;
            a         <= A_LAST;
            b         <= B_LAST;
            round_idx <= LAST_ROUND;
            nib_idx   <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            nib_idx <= nib_idx + 4'd1;
            if (nib_idx == 4'd15 && round_idx != 5'd0) begin
              // Reload the next round on the same edge so the stream has no bubble.
              round_idx <= round_dec;
              a         <= a_prev;
              b         <= b_prev;
              sr        <= next_word;
            end else begin
              sr <= {sr[59:0], 4'h0};
              if (nib_idx == 4'd15) begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_craft_dec_key_schedule.sv
// Scoreboard bench for craft_dec_key_schedule; expected nibbles come from a forward-LFSR golden model.
module tb_craft_dec_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic [3:0]   out;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   round_idx;
  logic [3:0]   nib_idx;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;
  bit rand_ready = 0;
  bit last_hs = 0;
  bit hold_saved = 0;
  logic [12:0] hold_val;
  logic [12:0] exp_q[$];

  int q_tab [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
  logic [3:0] a_tab [32];
  logic [2:0] b_tab [32];

  craft_dec_key_schedule #(.ROUNDS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .tweak(tweak),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .round_idx(round_idx), .nib_idx(nib_idx), .busy(busy), .done(done)
  );

  // Clock and reset block
  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [3:0] model_nib(input logic [127:0] k, input logic [63:0] tw,
                                           input int r, input int n);
    logic [63:0] kh, tt, v;
    kh = (r % 2 == 1) ? k[63:0] : k[127:64];
    tt = tw;
    if (r % 4 >= 2)
      for (int i = 0; i < 16; i++) tt[63-4*i -: 4] = 4'((tw >> (4 * (15 - q_tab[i]))) & 64'hF);
    v = kh ^ tt;
`ifdef CRAFT_DEC_RC_MERGE_EN
    if (n == 4) v[47:44] = v[47:44] ^ a_tab[r];
    if (n == 5) v[43:40] = v[43:40] ^ {1'b0, b_tab[r]};
`endif
    return v[63-4*n -: 4];
  endfunction

  task automatic push_expected(input logic [127:0] k, input logic [63:0] tw);
    for (int r = 31; r >= 0; r--)
      for (int n = 0; n < 16; n++)
        exp_q.push_back({5'(r), 4'(n), model_nib(k, tw, r, n)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic start_run(input logic [127:0] k, input logic [63:0] tw);
    push_expected(k, tw);
    @(posedge clk); #1;
    key = k; tweak = tw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: done never seen within 5000 cycles", name);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out"}, 32'(out), 32'h0);
    check({name, "_out_valid"}, 32'(out_valid), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_done"}, 32'(done), 32'h0);
    check({name, "_round_idx"}, 32'(round_idx), 32'h0);
    check({name, "_nib_idx"}, 32'(nib_idx), 32'h0);
  endtask

  // Scoreboard monitor: samples on the falling edge, ahead of the handshake edge.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst) begin
      if (last_hs || done) begin
        check("done_pulse", 32'(done), 32'(last_hs));
        if (last_hs) begin
          check("idle_after_done", {30'h0, out_valid, busy}, 32'h0);
          check("handshake_count", 32'(hs_count), 32'd512);
          hs_count = 0;
        end
      end
      if (hold_saved) check("hold_stable", 32'({round_idx, nib_idx, out}), 32'(hold_val));
      hold_saved = 0;
      last_hs = 0;
      if (out_valid) begin
        if (out_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stream: unexpected nibble r=%0d n=%0d out=%0h", round_idx, nib_idx, out);
          end else begin
            e = exp_q.pop_front();
            check("stream", 32'({round_idx, nib_idx, out}), 32'(e));
            last_hs = (e[12:4] == {5'd0, 4'd15});
          end
        end else begin
          hold_saved = 1;
          hold_val = {round_idx, nib_idx, out};
        end
      end
    end
  end

  initial begin
    bit hit;
    a_tab[0] = 4'h1;
    b_tab[0] = 3'h1;
    for (int r = 0; r < 31; r++) begin
      a_tab[r+1] = {a_tab[r][1] ^ a_tab[r][0], a_tab[r][3], a_tab[r][2], a_tab[r][1]};
      b_tab[r+1] = {b_tab[r][1] ^ b_tab[r][0], b_tab[r][2], b_tab[r][1]};
    end
    rst = 1'b1; start = 1'b0; key = '0; tweak = '0; out_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // All-zero key and tweak: only the round constants can show up.
    start_run(128'h0, 64'h0);
    wait_done("zero_run");

    // Tweak permutation visible in rounds 31 and 27..., identity in 29.
    start_run(128'h0, 64'h0123456789ABCDEF);
    wait_done("tweak_run");

    // Key half selection: K0 all ones, K1 zero.
    start_run({64'hFFFFFFFFFFFFFFFF, 64'h0}, 64'h0);
    wait_done("key_half_run");

    // Random backpressure with a mixed key and tweak.
    rand_ready = 1;
    start_run(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 64'hDEADBEEF01234567);
    wait_done("backpressure_run");
    rand_ready = 0;

    // Reset in the middle of round 17, nibble 9.
    start_run(128'h0123456789ABCDEFFEDCBA9876543210, 64'h13579BDF02468ACE);
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if (round_idx == 5'd17 && nib_idx == 4'd9) hit = 1;
    end
    check("reach_r17_n9", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    hs_count = 0;
    hold_saved = 0;
    last_hs = 0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 32'(out_valid), 32'h0);
    start_run(128'hA5A5A5A55A5A5A5A0123456789ABCDEF, 64'hFEDCBA9876543210);
    wait_done("after_reset_run");

    // start held high across a run: second run begins right after done.
    push_expected(128'h1111222233334444555566667777888, 64'h0F0F0F0FF0F0F0F0);
    push_expected(128'h1111222233334444555566667777888, 64'h0F0F0F0FF0F0F0F0);
    @(posedge clk); #1;
    key = 128'h1111222233334444555566667777888; tweak = 64'h0F0F0F0FF0F0F0F0; start = 1'b1;
    wait_done("held_start_first");
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart_valid", 32'(out_valid), 32'h1);
    check("restart_round", 32'(round_idx), 32'd31);
    wait_done("held_start_second");

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
